// File: rtl/xnor_descrambler.sv
// xnor_descrambler: receive-side XNOR descrambler with byte deserialiser.
// Regenerates the 7-bit LFSR key stream from SEED, recovers each accepted bit
// as din XNOR key, packs recovered bits MSB-first into bytes and flags the end
// of a frame after BYTES_PER_FRAME bytes.
// Ports:
//   clk, rst_n      - system clock (rising edge), async active-low reset
//   start           - pulse: reload seed, clear counters, enter RUN
//   din, din_valid  - scrambled serial bit and its qualifier
//   dout_bit(_valid)- recovered bit and one-cycle valid pulse
//   byte_out        - last completed byte (held until the next one)
//   byte_valid      - one-cycle pulse when byte_out updates
//   frame_done      - one-cycle pulse with the frame's last byte_valid
//   busy            - high while in RUN
module xnor_descrambler #(
   parameter logic [6:0]  SEED            = 7'h7F,
   parameter int unsigned BYTES_PER_FRAME = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       din,
   input  logic       din_valid,
   output logic       dout_bit,
   output logic       dout_bit_valid,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   output logic       frame_done,
   output logic       busy
);

   localparam int unsigned LFSR_W = 7;
   localparam int unsigned CNT_W  = 8;
   // An all-zero LFSR would lock up, so a zero seed falls back to all-ones.
   localparam logic [LFSR_W-1:0] SEED_EFF  = (SEED == 7'h00) ? 7'h7F : SEED;
   localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(BYTES_PER_FRAME - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t            r_state;
   logic [LFSR_W-1:0] r_lfsr;
   logic [2:0]        r_bit_cnt;
   logic [CNT_W-1:0]  r_byte_cnt;
   logic [6:0]        r_shift;
   logic              r_dout_bit;
   logic              r_dout_bit_valid;
   logic [7:0]        r_byte_out;
   logic              r_byte_valid;
   logic              r_frame_done;

   state_t            w_state_nxt;
   logic [LFSR_W-1:0] w_lfsr_nxt;
   logic [2:0]        w_bit_cnt_nxt;
   logic [CNT_W-1:0]  w_byte_cnt_nxt;
   logic [6:0]        w_shift_nxt;
   logic              w_dout_bit_nxt;
   logic              w_dout_bit_valid_nxt;
   logic [7:0]        w_byte_out_nxt;
   logic              w_byte_valid_nxt;
   logic              w_frame_done_nxt;
   logic              w_accept;
   logic              w_rec;

   // start has priority over a coincident data bit in either state.
   assign w_accept = (r_state == RUN) && din_valid && !start;
   assign w_rec    = din ~^ r_lfsr[LFSR_W-1];

   // Next-state, datapath and output pulse decode.
   always_comb begin
      w_state_nxt          = r_state;
      w_lfsr_nxt           = r_lfsr;
      w_bit_cnt_nxt        = r_bit_cnt;
      w_byte_cnt_nxt       = r_byte_cnt;
      w_shift_nxt          = r_shift;
      w_dout_bit_nxt       = r_dout_bit;
      w_dout_bit_valid_nxt = 1'b0;
      w_byte_out_nxt       = r_byte_out;
      w_byte_valid_nxt     = 1'b0;
      w_frame_done_nxt     = 1'b0;

      if (start) begin
         // Any partial byte is discarded silently.
         w_state_nxt    = RUN;
         w_lfsr_nxt     = SEED_EFF;
         w_bit_cnt_nxt  = 3'd0;
         w_byte_cnt_nxt = '0;
         w_shift_nxt    = '0;
      end else if (w_accept) begin
         w_lfsr_nxt           = {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
         w_dout_bit_nxt       = w_rec;
         w_dout_bit_valid_nxt = 1'b1;
         w_shift_nxt          = {r_shift[5:0], w_rec};
         if (r_bit_cnt == 3'd7) begin
            w_bit_cnt_nxt    = 3'd0;
            w_byte_out_nxt   = {r_shift, w_rec};
            w_byte_valid_nxt = 1'b1;
            if (r_byte_cnt == LAST_BYTE) begin
               // LFSR is left as-is; the next frame reloads it on start.
               w_frame_done_nxt = 1'b1;
               w_byte_cnt_nxt   = '0;
               w_state_nxt      = IDLE;
            end else begin
               w_byte_cnt_nxt = r_byte_cnt + CNT_W'(1);
            end
         end else begin
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
         end
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state          <= IDLE;
         r_lfsr           <= SEED_EFF;
         r_bit_cnt        <= 3'd0;
         r_byte_cnt       <= '0;
         r_shift          <= '0;
         r_dout_bit       <= 1'b0;
         r_dout_bit_valid <= 1'b0;
         r_byte_out       <= 8'h00;
         r_byte_valid     <= 1'b0;
         r_frame_done     <= 1'b0;
      end else begin
         r_state          <= w_state_nxt;
         r_lfsr           <= w_lfsr_nxt;
         r_bit_cnt        <= w_bit_cnt_nxt;
         r_byte_cnt       <= w_byte_cnt_nxt;
         r_shift          <= w_shift_nxt;
         r_dout_bit       <= w_dout_bit_nxt;
         r_dout_bit_valid <= w_dout_bit_valid_nxt;
         r_byte_out       <= w_byte_out_nxt;
         r_byte_valid     <= w_byte_valid_nxt;
         r_frame_done     <= w_frame_done_nxt;
      end
   end

   assign dout_bit       = r_dout_bit;
   assign dout_bit_valid = r_dout_bit_valid;
   assign byte_out       = r_byte_out;
   assign byte_valid     = r_byte_valid;
   assign frame_done     = r_frame_done;
   assign busy           = (r_state == RUN);

endmodule

// File: tb/tb_xnor_descrambler.sv
// Self-checking bench for xnor_descrambler (SEED=7'h7F, 4 bytes per frame).
// Stimulus pushes hand-computed expected bits/bytes into queues; a monitor
// on the falling edge pops and compares whenever the DUT emits a pulse.
// Key stream from 7'h7F with all-zero input yields bytes 01, FB, E7, AE.
module tb_xnor_descrambler;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       din;
   logic       din_valid;
   logic       dout_bit;
   logic       dout_bit_valid;
   logic [7:0] byte_out;
   logic       byte_valid;
   logic       frame_done;
   logic       busy;

   int errors = 0;
   int checks = 0;

   logic       bq[$];
   logic [8:0] byq[$];   // {frame_done expected, byte}
   logic       e_bit;
   logic [8:0] e_byte;

   xnor_descrambler #(
      .SEED            (7'h7F),
      .BYTES_PER_FRAME (4)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .din            (din),
      .din_valid      (din_valid),
      .dout_bit       (dout_bit),
      .dout_bit_valid (dout_bit_valid),
      .byte_out       (byte_out),
      .byte_valid     (byte_valid),
      .frame_done     (frame_done),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: compare every emitted pulse against the queued expectation.
   always @(negedge clk) begin
      if (dout_bit_valid) begin
         if (bq.size() == 0) chk("unexpected_bit", 32'(dout_bit_valid), 32'd0);
         else begin
            e_bit = bq.pop_front();
            chk("dout_bit", 32'(dout_bit), 32'(e_bit));
         end
      end
      if (byte_valid) begin
         if (byq.size() == 0) chk("unexpected_byte", 32'(byte_valid), 32'd0);
         else begin
            e_byte = byq.pop_front();
            chk("byte_out", 32'(byte_out), 32'(e_byte[7:0]));
            chk("frame_done", 32'(frame_done), 32'(e_byte[8]));
            chk("busy_at_byte", 32'(busy), 32'(!e_byte[8]));
            chk("bit_with_byte", 32'(dout_bit_valid), 32'd1);
         end
      end else if (frame_done) begin
         chk("frame_done_without_byte", 32'(frame_done), 32'd0);
      end
   end

   // Drive one cycle of inputs, 1 time unit after the rising edge.
   task automatic step(input logic s, input logic v, input logic d);
      @(posedge clk);
      #1;
      start     = s;
      din_valid = v;
      din       = d;
   endtask

   task automatic do_start();
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk("busy_after_start", 32'(busy), 32'd1);
   endtask

   // Send nbits of pattern (MSB first) with up to maxgap idle cycles before each.
   task automatic send_byte(input logic [7:0] pat, input logic [7:0] exp,
                            input int nbits, input logic last, input int maxgap);
      logic [7:0] p;
      logic [7:0] x;
      p = pat;
      x = exp;
      for (int i = 0; i < nbits; i++) begin
         repeat ($urandom_range(maxgap, 0)) step(1'b0, 1'b0, 1'b0);
         step(1'b0, 1'b1, p[7-i]);
         bq.push_back(x[7-i]);
      end
      if (nbits == 8) byq.push_back({last, x});
      step(1'b0, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; din = 1'b0; din_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      idle(2);
      chk("rst_outputs", {22'd0, dout_bit, dout_bit_valid, byte_out},  32'd0);
      chk("rst_pulses", {29'd0, byte_valid, frame_done, busy}, 32'd0);

      // All-zero full frame: 01, FB, E7, AE with frame_done on the last.
      do_start();
      send_byte(8'h00, 8'h01, 8, 1'b0, 0);
      send_byte(8'h00, 8'hFB, 8, 1'b0, 0);
      send_byte(8'h00, 8'hE7, 8, 1'b0, 0);
      send_byte(8'h00, 8'hAE, 8, 1'b1, 0);
      idle(3);
      chk("busy_after_frame", 32'(busy), 32'd0);
      chk("byte_out_held", 32'(byte_out), 32'hAE);

      // All-ones with random gaps: key stream unaffected by idle cycles.
      do_start();
      send_byte(8'hFF, 8'hFE, 8, 1'b0, 3);
      idle(2);

      // Mid-byte restart with coincident din_valid: partial byte and that bit dropped.
      do_start();
      send_byte(8'h00, 8'h01, 5, 1'b0, 0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk("busy_after_restart", 32'(busy), 32'd1);
      send_byte(8'h00, 8'h01, 8, 1'b0, 0);
      send_byte(8'h00, 8'hFB, 8, 1'b0, 1);
      send_byte(8'h00, 8'hE7, 8, 1'b0, 0);
      send_byte(8'h00, 8'hAE, 8, 1'b1, 2);
      idle(2);
      chk("busy_idle_after_restart_frame", 32'(busy), 32'd0);

      // IDLE: din_valid ignored, no pulses, LFSR untouched.
      for (int i = 0; i < 10; i++) step(1'b0, 1'(i % 2), 1'(i % 3 == 0));
      idle(2);
      chk("busy_in_idle", 32'(busy), 32'd0);
      do_start();
      send_byte(8'h00, 8'h01, 8, 1'b0, 0);
      idle(2);

      // Async reset mid-byte, between clock edges.
      send_byte(8'h00, 8'hFB, 3, 1'b0, 0);
      idle(2);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_outputs", {22'd0, dout_bit, dout_bit_valid, byte_out}, 32'd0);
      chk("async_rst_pulses", {29'd0, byte_valid, frame_done, busy}, 32'd0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      idle(2);
      chk("busy_after_reset", 32'(busy), 32'd0);
      do_start();
      send_byte(8'h00, 8'h01, 8, 1'b0, 0);
      idle(4);

      chk("bits_outstanding", 32'(bq.size()), 32'd0);
      chk("bytes_outstanding", 32'(byq.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
